shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- Parametrised universal register: N-bit replacement for the single-bit D flip-flop.
- Adds hold, serial shift, rotate, parallel load and clear operations.
- Adds a multi-cycle "shift by N" sequencer with a busy/done handshake.
- Used as the general storage/shift element for datapath and serial-interface labs.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits).
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  single-step operation enable; sampled only in IDLE.
- mode  input  3  operation select; encoding in Behaviour.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at the LSB on shift-left.
- sin_r  input  1  serial input entering at the MSB on shift-right.
- start  input  1  launches a multi-step operation; sampled only in IDLE.
- amt  input  AMT_W  step count for a multi-step operation; range 0..WIDTH.
- q  output  WIDTH  register contents.
- q_bar  output  WIDTH  bitwise complement of q; combinational, always ~q.
- sout  output  1  bit shifted out by the most recent shift; registered.
- busy  output  1  high while a multi-step operation is in progress.
- done  output  1  one-cycle pulse when a multi-step operation completes.

Behaviour:
- Reset, asynchronous, takes effect immediately and overrides everything, including mid-operation:
  - q = RESET_VALUE, q_bar = ~RESET_VALUE, sout = 0, busy = 0, done = 0.
  - State = IDLE; step counter = 0.
- mode encoding:
  - 000 hold.
  - 001 shift right: q <= {sin_r, q[W-1:1]}, sout <= q[0].
  - 010 shift left: q <= {q[W-2:0], sin_l}, sout <= q[W-1].
  - 011 rotate right: sout <= q[0].
  - 100 rotate left: sout <= q[W-1].
  - 101 parallel load: q <= d.
  - 110 clear: q <= 0.
  - 111 reserved, treated as hold.
  - sout changes only on shift or rotate operations.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start=1 with mode in 001..100 and amt >= 1: latch mode, latch cnt = amt, apply the first step this same edge, cnt <= amt-1.
    - If amt = 1, go to IDLE and pulse done next cycle.
    - Otherwise go to RUN; busy = 1 from the next cycle.
  - start=1 with amt = 0, or with a mode outside 001..100: q unchanged, done pulses for one cycle, stay in IDLE.
  - start=0 and en=1: apply mode once this edge.
  - start=0 and en=0: hold.
  - start and en both high: start takes priority; en is ignored.
- RUN:
  - Each edge applies the latched operation; sin_l/sin_r are sampled live every step. cnt decrements.
  - When cnt reaches 0 after a step: return to IDLE, busy = 0 and done = 1 in the same cycle.
  - en, start, mode, amt and d are ignored while busy = 1.
- Latency: an amt-step operation finishes amt edges after the start edge; done is high for exactly the cycle after the final step.
- amt > WIDTH is clamped to WIDTH. A rotate by WIDTH returns the original value.
- done is registered, never high together with busy, and never high for 2 consecutive cycles unless back-to-back starts are issued.
- A new start is accepted in the cycle done is high; state is IDLE.

Test Plan:
- Reset mid-RUN: WIDTH=8, q=8'hA5, start rotate-left amt=6, assert reset at step 3 -> q=8'h00 and busy=0 immediately (no clock edge), done never pulses.
- Parallel load then rotate: load d=8'hB4, then start rotate-right amt=3 -> busy high for 2 cycles; after 3 edges q=8'h96, sout=1, done pulses once.
- Serial shift-left: en=1, mode=010, sin_l pattern 1,0,1,1 from q=8'h00 -> q=8'h0B, q_bar=8'hF4.
- Priority and ignore: start (shift-right, amt=2, sin_r=1) together with en=1, mode=110, from q=8'h81 -> clear ignored, q=8'hE0. Mid-run en/mode changes have no effect.
- amt boundaries from q=8'h3C:
  - amt=0 -> done pulse, q unchanged, busy never high.
  - rotate-left amt=8 -> q=8'h3C after 8 steps.
  - amt=12 is clamped -> same result as amt=8.
- Reserved/hold: mode=111 with en=1, and mode=000 with en=1 -> q unchanged, sout unchanged, over 5 cycles.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal N-bit register: hold, serial shift, rotate, parallel load and
// clear, plus a multi-step "shift by amt" sequencer with busy/done.
//
// Handshake: start is sampled only while busy is low (IDLE). An accepted
// operation applies its first step on the start edge. done is a registered
// one-cycle pulse in the cycle after the final step (or after a rejected or
// zero-length start). busy and done are never high together.
module shift_reg_univ #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                 AMT_W       = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    input  logic              start,
    input  logic [AMT_W-1:0]  amt,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_bar,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               sout_q, sout_d;
    logic               done_q, done_d;

    logic               do_step;
    logic [2:0]         step_op;
    logic [AMT_W-1:0]   amt_c;
    logic               multi_ok;

    // Next-state, step selection and datapath for one register update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        q_d      = q_q;
        sout_d   = sout_q;
        done_d   = 1'b0;
        do_step  = 1'b0;
        step_op  = mode;
        amt_c    = (amt > AMT_MAX) ? AMT_MAX : amt;
        multi_ok = (mode == MODE_SHR) || (mode == MODE_SHL) ||
                   (mode == MODE_ROR) || (mode == MODE_ROL);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (multi_ok && (amt_c != '0)) begin
                        op_d    = mode;
                        do_step = 1'b1;
                        cnt_d   = amt_c - AMT_ONE;
                        if (amt_c == AMT_ONE) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        // Nothing to do: acknowledge immediately.
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    do_step = 1'b1;
                end
            end
            ST_RUN: begin
                do_step = 1'b1;
                step_op = op_q;
                cnt_d   = cnt_q - AMT_ONE;
                if (cnt_q == AMT_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_step) begin
            case (step_op)
                MODE_SHR: begin
                    q_d    = {sin_r, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], sin_l};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                MODE_LOAD: q_d = d;
                MODE_CLR:  q_d = '0;
                MODE_HOLD: q_d = q_q;
                default:   q_d = q_q;
            endcase
        end
    end

    // State and datapath registers; reset wins over everything, mid-run included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MODE_HOLD;
            q_q     <= RESET_VALUE;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
    assign sout  = sout_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8) with hand-computed expectations.
module tb_shift_reg_univ;

    localparam int W     = 8;
    localparam int AMT_W = $clog2(W) + 1;

    logic              clk;
    logic              reset;
    logic              en;
    logic [2:0]        mode;
    logic [W-1:0]      d;
    logic              sin_l;
    logic              sin_r;
    logic              start;
    logic [AMT_W-1:0]  amt;
    logic [W-1:0]      q;
    logic [W-1:0]      q_bar;
    logic              sout;
    logic              busy;
    logic              done;

    int n_vec;
    int n_err;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .start (start),
        .amt   (amt),
        .q     (q),
        .q_bar (q_bar),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    // Clock: 10 ns period, rising edge active.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] val);
        en = 1'b1; mode = 3'b101; d = val;
        tick();
        en = 1'b0; mode = 3'b000;
    endtask

    task automatic launch(input logic [2:0] m, input logic [AMT_W-1:0] a);
        start = 1'b1; mode = m; amt = a;
        tick();
        start = 1'b0; mode = 3'b000; amt = '0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; en = 1'b0; mode = 3'b000; d = '0;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; amt = '0;
        #3;
        check_val("rst_q", 32'(q), 32'h00);
        check_val("rst_qbar", 32'(q_bar), 32'hFF);
        check_val("rst_sout", 32'(sout), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Parallel load then rotate right by 3: B4 -> 5A -> 2D -> 96.
        load(8'hB4);
        check_val("load_q", 32'(q), 32'hB4);
        launch(3'b011, 4'd3);
        check_val("ror_s1_q", 32'(q), 32'h5A);
        check_val("ror_s1_busy", 32'(busy), 32'h1);
        tick();
        check_val("ror_s2_q", 32'(q), 32'h2D);
        check_val("ror_s2_busy", 32'(busy), 32'h1);
        tick();
        check_val("ror_q", 32'(q), 32'h96);
        check_val("ror_sout", 32'(sout), 32'h1);
        check_val("ror_done", 32'(done), 32'h1);
        check_val("ror_busy_end", 32'(busy), 32'h0);
        tick();
        check_val("ror_done_once", 32'(done), 32'h0);

        // Clear, then serial shift-left 1,0,1,1 -> 0B.
        en = 1'b1; mode = 3'b110;
        tick();
        check_val("clr_q", 32'(q), 32'h00);
        mode = 3'b010;
        sin_l = 1'b1; tick();
        sin_l = 1'b0; tick();
        sin_l = 1'b1; tick();
        sin_l = 1'b1; tick();
        en = 1'b0; mode = 3'b000; sin_l = 1'b0;
        check_val("shl_q", 32'(q), 32'h0B);
        check_val("shl_qbar", 32'(q_bar), 32'hF4);
        check_val("shl_sout", 32'(sout), 32'h0);

        // start beats en; mid-run en/mode/d are ignored. 81 -> C0 -> E0.
        load(8'h81);
        start = 1'b1; en = 1'b1; mode = 3'b001; amt = 4'd2; sin_r = 1'b1;
        tick();
        start = 1'b0; mode = 3'b110; d = 8'h55;
        check_val("pri_s1_q", 32'(q), 32'hC0);
        check_val("pri_s1_busy", 32'(busy), 32'h1);
        tick();
        en = 1'b0; mode = 3'b000; sin_r = 1'b0;
        check_val("pri_q", 32'(q), 32'hE0);
        check_val("pri_done", 32'(done), 32'h1);
        check_val("pri_sout", 32'(sout), 32'h0);

        // amt = 0: immediate done, nothing else.
        load(8'h3C);
        launch(3'b010, 4'd0);
        check_val("amt0_done", 32'(done), 32'h1);
        check_val("amt0_busy", 32'(busy), 32'h0);
        check_val("amt0_q", 32'(q), 32'h3C);
        tick();
        check_val("amt0_done_once", 32'(done), 32'h0);

        // Rotate left by WIDTH returns the original value.
        launch(3'b100, 4'd8);
        for (int i = 1; i < 8; i++) begin
            check_val($sformatf("rol8_busy%0d", i), 32'(busy), 32'h1);
            check_val($sformatf("rol8_nodone%0d", i), 32'(done), 32'h0);
            tick();
        end
        check_val("rol8_q", 32'(q), 32'h3C);
        check_val("rol8_done", 32'(done), 32'h1);
        check_val("rol8_busy_end", 32'(busy), 32'h0);
        check_val("rol8_sout", 32'(sout), 32'h0);

        // Back-to-back start in the done cycle; amt=12 clamps to 8.
        launch(3'b100, 4'd12);
        check_val("rol12_s1_q", 32'(q), 32'h78);
        for (int i = 1; i < 8; i++) begin
            check_val($sformatf("rol12_busy%0d", i), 32'(busy), 32'h1);
            tick();
        end
        check_val("rol12_q", 32'(q), 32'h3C);
        check_val("rol12_done", 32'(done), 32'h1);
        tick();
        check_val("rol12_done_once", 32'(done), 32'h0);

        // Reserved and hold modes leave q and sout alone. 81 rol1 -> 03, sout=1.
        load(8'h81);
        en = 1'b1; mode = 3'b100;
        tick();
        check_val("pre_hold_q", 32'(q), 32'h03);
        check_val("pre_hold_sout", 32'(sout), 32'h1);
        mode = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("rsv_q%0d", i), 32'(q), 32'h03);
            check_val($sformatf("rsv_sout%0d", i), 32'(sout), 32'h1);
        end
        mode = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("hold_q%0d", i), 32'(q), 32'h03);
            check_val($sformatf("hold_sout%0d", i), 32'(sout), 32'h1);
        end
        en = 1'b0;

        // Asynchronous reset in the middle of a rotate-left by 6.
        load(8'hA5);
        launch(3'b100, 4'd6);
        tick();
        tick();
        check_val("mid_busy", 32'(busy), 32'h1);
        check_val("mid_q", 32'(q), 32'h2D);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_q", 32'(q), 32'h00);
        check_val("arst_qbar", 32'(q_bar), 32'hFF);
        check_val("arst_busy", 32'(busy), 32'h0);
        check_val("arst_sout", 32'(sout), 32'h0);
        check_val("arst_done", 32'(done), 32'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val($sformatf("post_rst_done%0d", i), 32'(done), 32'h0);
            check_val($sformatf("post_rst_busy%0d", i), 32'(busy), 32'h0);
            check_val($sformatf("post_rst_q%0d", i), 32'(q), 32'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
